// File: rtl/obs_pkg.sv
// Shared definitions for the obstacle scheduler: type encoding, LFSR constants and sprite width.
package obs_pkg;

    typedef enum logic [2:0] {
        CACTUS_S = 3'd0,
        CACTUS_L = 3'd1,
        CACTUS_G = 3'd2,
        BIRD_LO  = 3'd3,
        BIRD_MID = 3'd4,
        BIRD_HI  = 3'd5
    } obs_type_e;

    localparam int NUM_TYPES = 6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions of a right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int SPR_W = 2;

    // Folds a 3-bit random draw onto the six legal obstacle types.
    function automatic logic [2:0] lfsr_to_type(input logic [2:0] raw);
        if (raw >= 3'(NUM_TYPES))
            return raw - 3'(NUM_TYPES);
        return raw;
    endfunction

endpackage

// File: rtl/obs_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; only the low byte is consumed by the scheduler.
module obs_lfsr
    import obs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LFSR_SEED;
        else
            state <= {^(state & LFSR_TAPS), state[15:1]};
    end

    assign value = state[7:0];

endmodule

// File: rtl/obs_scheduler.sv
// Obstacle slot ring: per-frame move/retire/spawn and scanline time-multiplexing onto one renderer.
// Optional speed ramp enabled by defining OBS_SCHED_RAMP_EN.
module obs_scheduler #(
    parameter int CONV      = 0,
    parameter int NUM_SLOTS = 2,
    parameter int SPAWN_X   = 300,
    parameter int SPR_W     = obs_pkg::SPR_W,
    parameter int MIN_GAP   = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_frame_tick,
    input  logic                 i_run,
    input  logic                 i_clear,
    input  logic [2:0]           i_speed,
    input  logic [9-CONV:0]      i_hpos,
    output logic [2:0]           o_obs_type,
    output logic [9-CONV:0]      o_xpos,
    output logic                 o_obs_valid,
    output logic [NUM_SLOTS-1:0] o_active,
    output logic                 o_pass,
    output logic                 o_busy
);

    import obs_pkg::*;

    localparam int XW = 10 - CONV;
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = IW + 1;
    localparam int GW = 8;

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t               state, state_d;
    logic [XW-1:0]        slot_x [NUM_SLOTS];
    logic [2:0]           slot_t [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active;
    logic [IW-1:0]        head, tail, mv_ptr;
    logic [CW-1:0]        count, mv_left;
    logic [GW-1:0]        gap;
    logic [2:0]           spd, eff_speed;
    logic [7:0]           rnd;
    logic                 mv_load, mv_step, spawn_step, retire, do_spawn;
    logic [IW-1:0]        sel, sel_d;
    logic                 sel_end, sel_end_d;

    obs_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (rnd)
    );

`ifdef OBS_SCHED_RAMP_EN
    logic [7:0] frame_cnt;
    logic [2:0] ramp_off;

    function automatic logic [2:0] sat_speed(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum > 4'd7) ? 3'd7 : sum[2:0];
    endfunction

    assign eff_speed = sat_speed(i_speed, ramp_off);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            frame_cnt <= '0;
            ramp_off  <= '0;
        end else if (mv_load) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (frame_cnt == 8'hFF && ramp_off != 3'd7)
                ramp_off <= ramp_off + 3'd1;
        end
    end
`else
    assign eff_speed = i_speed;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        mv_load    = 1'b0;
        mv_step    = 1'b0;
        spawn_step = 1'b0;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_frame_tick && i_run) begin
                        state_d = MOVE;
                        mv_load = 1'b1;
                    end
                end
                MOVE: begin
                    mv_step = (mv_left != '0);
                    if (mv_left <= CW'(1))
                        state_d = SPAWN;
                end
                SPAWN: begin
                    spawn_step = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign retire   = mv_step && active[mv_ptr] && (slot_x[mv_ptr] < XW'(spd));
    assign do_spawn = spawn_step && (gap == '0) && (count < CW'(NUM_SLOTS)) && rnd[0];

    // Ring bookkeeping; retirements always come off the head because ring order is x order.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            active  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            gap     <= GW'(MIN_GAP);
            mv_ptr  <= '0;
            mv_left <= '0;
            spd     <= '0;
            o_pass  <= 1'b0;
        end else begin
            o_pass <= retire;
            if (mv_load) begin
                mv_ptr  <= head;
                mv_left <= count;
                spd     <= eff_speed;
            end
            if (mv_step) begin
                mv_ptr  <= mv_ptr + IW'(1);
                mv_left <= mv_left - CW'(1);
                if (retire) begin
                    active[mv_ptr] <= 1'b0;
                    head           <= head + IW'(1);
                    count          <= count - CW'(1);
                end
            end
            if (spawn_step) begin
                if (gap != '0) begin
                    gap <= gap - GW'(1);
                end else if (do_spawn) begin
                    active[tail] <= 1'b1;
                    tail         <= tail + IW'(1);
                    count        <= count + CW'(1);
                    gap          <= GW'(MIN_GAP) + GW'(rnd[7:4]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mv_step && !retire && active[mv_ptr])
            slot_x[mv_ptr] <= slot_x[mv_ptr] - XW'(spd);
        if (do_spawn) begin
            slot_x[tail] <= XW'(SPAWN_X);
            slot_t[tail] <= lfsr_to_type(rnd[3:1]);
        end
    end

    // sel_end stops the walk once the last live slot is passed, so a full ring cannot wrap back to head.
    always_comb begin
        sel_d     = sel;
        sel_end_d = sel_end;
        if (i_hpos == '0) begin
            sel_d     = head;
            sel_end_d = 1'b0;
        end else if (!sel_end && active[sel] &&
                     ({1'b0, i_hpos} >= ({1'b0, slot_x[sel]} + (XW+1)'(SPR_W)))) begin
            sel_d     = sel + IW'(1);
            sel_end_d = ((sel + IW'(1)) == tail);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel         <= '0;
            sel_end     <= 1'b0;
            o_xpos      <= '0;
            o_obs_type  <= '0;
            o_obs_valid <= 1'b0;
        end else if (state == IDLE) begin
            sel         <= sel_d;
            sel_end     <= sel_end_d;
            o_xpos      <= slot_x[sel_d];
            o_obs_type  <= slot_t[sel_d];
            o_obs_valid <= active[sel_d] && !sel_end_d;
        end
    end

    assign o_busy   = (state != IDLE);
    assign o_active = active;

endmodule

// File: tb/tb_obs_scheduler.sv
// Self-checking bench for obs_scheduler: randomized frames against a queue-based obstacle model.
module tb_obs_scheduler;

    localparam int N       = 2;
    localparam int SPAWN_X = 300;
    localparam int SPR_W   = 2;
    localparam int MIN_GAP = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_frame_tick = 1'b0;
    logic         i_run = 1'b0;
    logic         i_clear = 1'b0;
    logic [2:0]   i_speed = 3'd0;
    logic [9:0]   i_hpos = 10'd0;
    logic [2:0]   o_obs_type;
    logic [9:0]   o_xpos;
    logic         o_obs_valid;
    logic [N-1:0] o_active;
    logic         o_pass;
    logic         o_busy;

    always #5 clk = ~clk;

    obs_scheduler #(
        .CONV      (0),
        .NUM_SLOTS (N),
        .SPAWN_X   (SPAWN_X),
        .SPR_W     (SPR_W),
        .MIN_GAP   (MIN_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (i_frame_tick),
        .i_run        (i_run),
        .i_clear      (i_clear),
        .i_speed      (i_speed),
        .i_hpos       (i_hpos),
        .o_obs_type   (o_obs_type),
        .o_xpos       (o_xpos),
        .o_obs_valid  (o_obs_valid),
        .o_active     (o_active),
        .o_pass       (o_pass),
        .o_busy       (o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every clock.
    logic [15:0] lm;
    function automatic logic [15:0] lstep(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction
    always @(posedge clk) begin
        if (!rst_n) lm <= 16'hACE1;
        else        lm <= lstep(lm);
    end

    // Obstacle model: queue ordered oldest first, plus ring head index and spawn gap.
    int qx[$];
    int qt[$];
    int mhead, mgap, moff, mfcnt;

    task automatic model_clear();
        qx.delete();
        qt.delete();
        mhead = 0;
        mgap  = MIN_GAP;
        moff  = 0;
        mfcnt = 0;
    endtask

    task automatic do_frame(input int spd, input bit run, input bit extra);
        int m, eff, retired, pcnt, bcnt;
        logic [15:0] l;
        logic [N-1:0] mask;
        int nx[$];
        int nt[$];
        i_frame_tick = 1'b1;
        i_run        = run;
        i_speed      = 3'(spd);
        i_hpos       = '0;
        l       = lm;
        m       = 0;
        retired = 0;
        if (run) begin
            m   = (qx.size() == 0) ? 1 : qx.size();
            eff = spd;
`ifdef OBS_SCHED_RAMP_EN
            eff = (spd + moff > 7) ? 7 : spd + moff;
            mfcnt++;
            if (mfcnt == 256) begin
                mfcnt = 0;
                if (moff < 7) moff++;
            end
`endif
            foreach (qx[i]) begin
                if (qx[i] < eff) begin
                    retired++;
                end else begin
                    nx.push_back(qx[i] - eff);
                    nt.push_back(qt[i]);
                end
            end
            qx = nx;
            qt = nt;
            mhead = (mhead + retired) % N;
            // Spawn decision sees the LFSR m+1 clocks after the tick cycle.
            for (int s = 0; s <= m; s++) l = lstep(l);
            if (mgap != 0) begin
                mgap--;
            end else if (qx.size() < N && l[0]) begin
                qx.push_back(SPAWN_X);
                qt.push_back(int'(l[3:1]) % 6);
                mgap = MIN_GAP + int'(l[7:4]);
            end
        end
        @(negedge clk);
        i_frame_tick = extra;
        bcnt = 0;
        pcnt = 0;
        while (o_busy && bcnt < 20) begin
            if (o_pass) pcnt++;
            bcnt++;
            @(negedge clk);
            i_frame_tick = 1'b0;
        end
        i_frame_tick = 1'b0;
        mask = '0;
        for (int i = 0; i < qx.size(); i++) mask[(mhead + i) % N] = 1'b1;

        n_checks++;
        if (bcnt !== (run ? m + 1 : 0)) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d expected %0d", bcnt, run ? m + 1 : 0);
        end
        n_checks++;
        if (pcnt !== retired) begin
            n_fail++;
            $display("FAIL pass_pulses: got %0d expected %0d", pcnt, retired);
        end
        n_checks++;
        if (o_active !== mask) begin
            n_fail++;
            $display("FAIL active_mask: got %b expected %b", o_active, mask);
        end
        @(negedge clk);
        n_checks++;
        if (o_pass !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_idle: got %b expected 0", o_pass);
        end
        n_checks++;
        if (o_obs_valid !== (qx.size() > 0)) begin
            n_fail++;
            $display("FAIL head_valid: got %b expected %0d", o_obs_valid, qx.size() > 0);
        end
        if (qx.size() > 0) begin
            n_checks++;
            if (o_xpos !== 10'(qx[0]) || o_obs_type !== 3'(qt[0])) begin
                n_fail++;
                $display("FAIL head_slot: got x=%0d t=%0d expected x=%0d t=%0d",
                         o_xpos, o_obs_type, qx[0], qt[0]);
            end
        end
    endtask

    task automatic sweep(input int hmax);
        int k;
        k = 0;
        for (int h = 0; h <= hmax; h++) begin
            i_hpos = 10'(h);
            if (h == 0) k = 0;
            else if (k < qx.size() && h >= qx[k] + SPR_W) k++;
            @(negedge clk);
            n_checks++;
            if (o_obs_valid !== (k < qx.size())) begin
                n_fail++;
                $display("FAIL sweep_valid h=%0d: got %b expected %0d", h, o_obs_valid, k < qx.size());
            end
            if (k < qx.size()) begin
                n_checks++;
                if (o_xpos !== 10'(qx[k]) || o_obs_type !== 3'(qt[k])) begin
                    n_fail++;
                    $display("FAIL sweep_slot h=%0d: got x=%0d t=%0d expected x=%0d t=%0d",
                             h, o_xpos, o_obs_type, qx[k], qt[k]);
                end
            end
        end
        i_hpos = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_obs_type, o_xpos, o_obs_valid, o_active, o_pass, o_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got type=%0d x=%0d v=%b act=%b pass=%b busy=%b expected all 0",
                     o_obs_type, o_xpos, o_obs_valid, o_active, o_pass, o_busy);
        end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_active !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b act=%b expected 0", o_busy, o_active);
        end
    endtask

    task automatic test_first_spawn();
        repeat (50) do_frame(2, 1'b1, 1'b0);
        sweep(330);
    endtask

    task automatic test_freeze();
        repeat (4) do_frame(5, 1'b0, 1'b0);
        sweep(330);
    endtask

    task automatic test_back_to_back();
        repeat (6) do_frame(1, 1'b1, 1'b1);
        sweep(330);
    endtask

    task automatic test_random();
        for (int f = 0; f < 120; f++) begin
            do_frame($urandom_range(0, 7), $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0);
            if (f % 10 == 9) sweep(330);
        end
    endtask

    task automatic test_retire();
        repeat (60) do_frame(7, 1'b1, 1'b0);
        sweep(330);
    endtask

    task automatic test_full_table();
        int f;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        model_clear();
        f = 0;
        while (!(qx.size() == N && mgap == 0) && f < 400) begin
            do_frame(0, 1'b1, 1'b0);
            f++;
        end
        n_checks++;
        if (!(qx.size() == N && mgap == 0)) begin
            n_fail++;
            $display("FAIL full_table_reach: got %0d slots after %0d frames expected %0d", qx.size(), f, N);
        end
        repeat (5) do_frame(0, 1'b1, 1'b0);
        n_checks++;
        if (o_active !== {N{1'b1}}) begin
            n_fail++;
            $display("FAIL full_table_mask: got %b expected all ones", o_active);
        end
        sweep(330);
    endtask

    task automatic test_clear_mid_move();
        i_frame_tick = 1'b1;
        i_run        = 1'b1;
        i_speed      = 3'd1;
        i_hpos       = '0;
        @(negedge clk);
        i_frame_tick = 1'b0;
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        n_checks++;
        if (o_active !== '0 || o_busy !== 1'b0 || o_pass !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_move: got act=%b busy=%b pass=%b expected 0/0/0", o_active, o_busy, o_pass);
        end
        model_clear();
        repeat (3) do_frame(2, 1'b1, 1'b0);
        sweep(40);
    endtask

    task automatic test_clear_with_tick();
        i_frame_tick = 1'b1;
        i_run        = 1'b1;
        i_clear      = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0;
        i_clear      = 1'b0;
        model_clear();
        n_checks++;
        if (o_busy !== 1'b0 || o_active !== '0) begin
            n_fail++;
            $display("FAIL clear_with_tick: got busy=%b act=%b expected 0/0", o_busy, o_active);
        end
        @(negedge clk);
    endtask

    task automatic test_ramp();
        repeat (260) do_frame(7, 1'b1, 1'b0);
        sweep(330);
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_freeze();
        test_back_to_back();
        test_random();
        test_retire();
        test_full_table();
        test_clear_mid_move();
        test_clear_with_tick();
        test_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
